// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access encodings,
// MMIO register offsets, the address region select and the misalignment rule.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MMIO_GPIO   = 4'h0;
  localparam logic [3:0] MMIO_CYCLE  = 4'h4;
  localparam logic [3:0] MMIO_STORES = 4'h8;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // Half-word accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane logic for the data-memory port: load extraction with
// sign/zero extension, and store lane replication with byte enables.
module load_extend
  import data_mem_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  output logic [31:0] ld_data,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_funct3,
  output logic [31:0] st_word,
  output logic [3:0]  st_be
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Select the addressed byte/half and extend it; half lanes use only off[1].
  always_comb begin
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    ld_data = ld_word;
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      2'd3:    ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    if (ld_off[1]) begin
      ld_half = ld_word[31:16];
    end else begin
      ld_half = ld_word[15:0];
    end
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {24'h000000, ld_byte};
      F3_HU:   ld_data = {16'h0000, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  // Replicate store data across lanes and enable only the addressed lanes.
  always_comb begin
    st_word = st_data;
    st_be   = 4'b1111;
    case (st_funct3)
      F3_B: begin
        st_word = {4{st_data[7:0]}};
        st_be   = 4'b0001 << st_off;
      end
      F3_H: begin
        st_word = {2{st_data[15:0]}};
        if (st_off[1]) begin
          st_be = 4'b1100;
        end else begin
          st_be = 4'b0011;
        end
      end
      F3_W: begin
        st_word = st_data;
        st_be   = 4'b1111;
      end
      default: begin
        st_word = st_data;
        st_be   = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: byte-enable RAM, GPIO/cycle/store-count MMIO window,
// load data returned one cycle after the address.
// Optional build macro: DATA_MEM_MISALIGN_TRAP_EN drops misaligned accesses and
// raises misalign_err; without it low address bits below the access size are ignored.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [2:0]  funct3M,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic        misalign_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_LIMIT = 32'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_rd_r, mmio_word_r, gpio_r, cycle_r, stores_r;
  logic [1:0]  off_r;
  logic [2:0]  f3_r;
  logic        mis_r;
  region_e     src_r;

  region_e     region_s;
  logic        mis_s, ram_we_s, gpio_we_s;
  logic [AW-1:0] idx_s;
  logic [31:0] st_word_s, mmio_word_s, rd_word_s;
  logic [3:0]  st_be_s;

  assign idx_s = Mem_WrAddr[AW+1:2];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign mis_s = is_misaligned(funct3M, Mem_WrAddr[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  assign ram_we_s  = MemWriteM && !mis_s && (region_s == REG_RAM);
  assign gpio_we_s = MemWriteM && !mis_s && (region_s == REG_MMIO) &&
                     (Mem_WrAddr[3:2] == MMIO_GPIO[3:2]);

  // Address decode: RAM has priority, then the 16-byte MMIO window.
  always_comb begin
    region_s = REG_NONE;
    if (Mem_WrAddr < RAM_LIMIT) begin
      region_s = REG_RAM;
    end else if (Mem_WrAddr[31:4] == MMIO_BASE[31:4]) begin
      region_s = REG_MMIO;
    end else begin
      region_s = REG_NONE;
    end
  end

  // MMIO read mux; the cycle counter is captured at the address cycle.
  always_comb begin
    mmio_word_s = 32'h0000_0000;
    case ({Mem_WrAddr[3:2], 2'b00})
      MMIO_GPIO:   mmio_word_s = gpio_r;
      MMIO_CYCLE:  mmio_word_s = cycle_r;
      MMIO_STORES: mmio_word_s = stores_r;
      default:     mmio_word_s = 32'h0000_0000;
    endcase
  end

  // Byte-enable RAM write and synchronous word read; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be_s[i]) begin
          mem[idx_s][8*i +: 8] <= st_word_s[8*i +: 8];
        end
      end
    end
    ram_rd_r <= mem[idx_s];
  end

  // GPIO register, free-running cycle counter and committed-store counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_r   <= 32'h0000_0000;
      cycle_r  <= 32'h0000_0000;
      stores_r <= 32'h0000_0000;
    end else begin
      cycle_r <= cycle_r + 32'd1;
      if (gpio_we_s) begin
        for (int i = 0; i < 4; i++) begin
          if (st_be_s[i]) begin
            gpio_r[8*i +: 8] <= st_word_s[8*i +: 8];
          end
        end
      end
      if (ram_we_s || gpio_we_s) begin
        stores_r <= stores_r + 32'd1;
      end
    end
  end

  // Load pipeline stage: stores, misaligned and unmapped accesses return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_r       <= REG_NONE;
      mmio_word_r <= 32'h0000_0000;
      off_r       <= 2'b00;
      f3_r        <= 3'b000;
      mis_r       <= 1'b0;
    end else begin
      src_r       <= (MemWriteM || mis_s) ? REG_NONE : region_s;
      mmio_word_r <= mmio_word_s;
      off_r       <= Mem_WrAddr[1:0];
      f3_r        <= funct3M;
      mis_r       <= mis_s;
    end
  end

  // Pick the registered word source for the W-stage extraction.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    case (src_r)
      REG_RAM:  rd_word_s = ram_rd_r;
      REG_MMIO: rd_word_s = mmio_word_r;
      default:  rd_word_s = 32'h0000_0000;
    endcase
  end

  load_extend u_lanes (
    .ld_word   (rd_word_s),
    .ld_off    (off_r),
    .ld_funct3 (f3_r),
    .ld_data   (ReadData),
    .st_data   (Mem_WrData),
    .st_off    (Mem_WrAddr[1:0]),
    .st_funct3 (funct3M),
    .st_word   (st_word_s),
    .st_be     (st_be_s)
  );

  assign gpio_out     = gpio_r;
  assign misalign_err = mis_r;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: per-feature tasks build stimulus
// tables, expected results go through a scoreboard queue at drive time and are
// popped and compared one cycle later. Honours DATA_MEM_MISALIGN_TRAP_EN.
module tb_data_mem_resp;

  localparam logic [2:0]  LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [31:0] MMIO = 32'h0000_4000;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, MemWriteM;
  logic [31:0] Mem_WrAddr, Mem_WrData, ReadData, gpio_out;
  logic [2:0]  funct3M;
  logic        misalign_err;

  data_mem_resp dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM    (MemWriteM),
    .Mem_WrAddr   (Mem_WrAddr),
    .Mem_WrData   (Mem_WrData),
    .funct3M      (funct3M),
    .ReadData     (ReadData),
    .gpio_out     (gpio_out),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [31:0] rd;
    logic        mis;
    logic [31:0] gpio;
  } op_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic [31:0] gpio;
  } exp_t;

  op_t         ops[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_gpio = 32'h0;
  logic [31:0] exp_stores = 32'h0;

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input logic [31:0] rd, input logic mis);
    op_t o;
    o.we = we; o.addr = a; o.data = d; o.f3 = f3;
    o.rd = rd; o.mis = mis; o.gpio = exp_gpio;
    ops.push_back(o);
  endtask

  task automatic drive(input op_t o);
    exp_t e;
    MemWriteM = o.we; Mem_WrAddr = o.addr; Mem_WrData = o.data; funct3M = o.f3;
    e.rd = o.rd; e.mis = o.mis; e.gpio = o.gpio;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; MemWriteM = 1'b0; Mem_WrAddr = 32'h0; Mem_WrData = 32'h0; funct3M = LW;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 3;
    if (ReadData !== 32'h0) begin n_fail++; $display("FAIL reset ReadData got %h expected 00000000", ReadData); end
    if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset gpio_out got %h expected 00000000", gpio_out); end
    if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset misalign_err got %b expected 0", misalign_err); end
    reset = 1'b0; exp_gpio = 32'h0; exp_stores = 32'h0;
    ops.delete();
    repeat (5) add(1'b0, 32'h0000_8000, 32'h0, LW, 32'h0, 1'b0);
    add(1'b0, MMIO + 32'h4, 32'h0, LW, 32'd5, 1'b0);
    add(1'b0, MMIO + 32'h8, 32'h0, LW, 32'd0, 1'b0);
    foreach (ops[i]) begin
      drive(ops[i]); e = exp_q.pop_front();
      n_checks += 2;
      if (ReadData !== e.rd) begin n_fail++; $display("FAIL cycle_count[%0d] ReadData got %h expected %h", i, ReadData, e.rd); end
      if (misalign_err !== e.mis) begin n_fail++; $display("FAIL cycle_count[%0d] misalign_err got %b expected %b", i, misalign_err, e.mis); end
    end
  endtask

  task automatic test_mmio();
    exp_t e;
    ops.delete();
    exp_gpio = 32'h0000_00F0; exp_stores++;
    add(1'b1, MMIO, 32'h0000_00F0, LW, 32'h0, 1'b0);
    add(1'b0, MMIO + 32'h8, 32'h0, LW, exp_stores, 1'b0);
    exp_gpio = 32'h0000_85F0; exp_stores++;
    add(1'b1, MMIO + 32'h1, 32'hFFFF_FF85, LB, 32'h0, 1'b0);
    add(1'b0, MMIO + 32'h1, 32'h0, LB, 32'hFFFF_FF85, 1'b0);
    add(1'b0, MMIO + 32'h1, 32'h0, LBU, 32'h0000_0085, 1'b0);
    add(1'b0, MMIO, 32'h0, LW, 32'h0000_85F0, 1'b0);
    add(1'b1, MMIO + 32'h8, 32'h0000_FFFF, LW, 32'h0, 1'b0);
    add(1'b0, MMIO + 32'h8, 32'h0, LW, exp_stores, 1'b0);
    add(1'b0, MMIO + 32'hC, 32'h0, LW, 32'h0, 1'b0);
    foreach (ops[i]) begin
      drive(ops[i]); e = exp_q.pop_front();
      n_checks += 3;
      if (ReadData !== e.rd) begin n_fail++; $display("FAIL mmio[%0d] ReadData got %h expected %h", i, ReadData, e.rd); end
      if (misalign_err !== e.mis) begin n_fail++; $display("FAIL mmio[%0d] misalign_err got %b expected %b", i, misalign_err, e.mis); end
      if (gpio_out !== e.gpio) begin n_fail++; $display("FAIL mmio[%0d] gpio_out got %h expected %h", i, gpio_out, e.gpio); end
    end
  endtask

  task automatic test_ram_subword();
    exp_t e;
    ops.delete();
    add(1'b1, 32'h10, 32'hDEAD_BEEF, LW, 32'h0, 1'b0); exp_stores++;
    add(1'b0, 32'h10, 32'h0, LW, 32'hDEAD_BEEF, 1'b0);
    add(1'b1, 32'h10, 32'h1122_3344, LW, 32'h0, 1'b0); exp_stores++;
    add(1'b1, 32'h13, 32'hAAAA_AA80, LB, 32'h0, 1'b0); exp_stores++;
    add(1'b0, 32'h13, 32'h0, LB, 32'hFFFF_FF80, 1'b0);
    add(1'b0, 32'h13, 32'h0, LBU, 32'h0000_0080, 1'b0);
    add(1'b0, 32'h10, 32'h0, LW, 32'h8022_3344, 1'b0);
    add(1'b0, 32'h10, 32'h0, LB, 32'h0000_0044, 1'b0);
    add(1'b0, 32'h12, 32'h0, LHU, 32'h0000_8022, 1'b0);
    add(1'b1, 32'h20, 32'h5566_7788, LW, 32'h0, 1'b0); exp_stores++;
    add(1'b1, 32'h22, 32'h1234_ABCD, LH, 32'h0, 1'b0); exp_stores++;
    add(1'b0, 32'h22, 32'h0, LH, 32'hFFFF_ABCD, 1'b0);
    add(1'b0, 32'h22, 32'h0, LHU, 32'h0000_ABCD, 1'b0);
    add(1'b0, 32'h20, 32'h0, LW, 32'hABCD_7788, 1'b0);
    add(1'b0, 32'h20, 32'h0, LH, 32'h0000_7788, 1'b0);
    add(1'b0, 32'h21, 32'h0, LB, 32'h0000_0077, 1'b0);
    add(1'b0, MMIO + 32'h8, 32'h0, LW, exp_stores, 1'b0);
    foreach (ops[i]) begin
      drive(ops[i]); e = exp_q.pop_front();
      n_checks += 2;
      if (ReadData !== e.rd) begin n_fail++; $display("FAIL ram_subword[%0d] ReadData got %h expected %h", i, ReadData, e.rd); end
      if (misalign_err !== e.mis) begin n_fail++; $display("FAIL ram_subword[%0d] misalign_err got %b expected %b", i, misalign_err, e.mis); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] d;
    ops.delete();
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      add(1'b1, 32'h100 + 32'(4 * k), d, LW, 32'h0, 1'b0); exp_stores++;
      add(1'b0, 32'h100 + 32'(4 * k), 32'h0, LW, d, 1'b0);
    end
    add(1'b0, MMIO + 32'h8, 32'h0, LW, exp_stores, 1'b0);
    foreach (ops[i]) begin
      drive(ops[i]); e = exp_q.pop_front();
      n_checks += 1;
      if (ReadData !== e.rd) begin n_fail++; $display("FAIL back_to_back[%0d] ReadData got %h expected %h", i, ReadData, e.rd); end
    end
  endtask

  task automatic test_misalign();
    exp_t e;
    ops.delete();
    add(1'b1, 32'h10, 32'h1111_1111, LW, 32'h0, 1'b0); exp_stores++;
    add(1'b1, 32'h12, 32'hCAFE_F00D, LW, 32'h0, TRAP);
    if (!TRAP) exp_stores++;
    add(1'b0, 32'h10, 32'h0, LW, TRAP ? 32'h1111_1111 : 32'hCAFE_F00D, 1'b0);
    add(1'b0, 32'h11, 32'h0, LH, TRAP ? 32'h0 : 32'hFFFF_F00D, TRAP);
    add(1'b0, 32'h13, 32'h0, LW, TRAP ? 32'h0 : 32'hCAFE_F00D, TRAP);
    add(1'b0, 32'h13, 32'h0, LB, TRAP ? 32'h0000_0011 : 32'hFFFF_FFCA, 1'b0);
    add(1'b0, MMIO + 32'h8, 32'h0, LW, exp_stores, 1'b0);
    foreach (ops[i]) begin
      drive(ops[i]); e = exp_q.pop_front();
      n_checks += 2;
      if (ReadData !== e.rd) begin n_fail++; $display("FAIL misalign[%0d] ReadData got %h expected %h", i, ReadData, e.rd); end
      if (misalign_err !== e.mis) begin n_fail++; $display("FAIL misalign[%0d] misalign_err got %b expected %b", i, misalign_err, e.mis); end
    end
  endtask

  task automatic test_unmapped();
    exp_t e;
    ops.delete();
    add(1'b1, 32'h0000_8000, 32'h1234_5678, LW, 32'h0, 1'b0);
    add(1'b1, MMIO + 32'h4, 32'h0000_FFFF, LW, 32'h0, 1'b0);
    add(1'b0, MMIO + 32'h8, 32'h0, LW, exp_stores, 1'b0);
    add(1'b0, 32'h0000_8000, 32'h0, LW, 32'h0, 1'b0);
    add(1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, LW, 32'h0, 1'b0); exp_stores++;
    add(1'b0, 32'h0000_0FFC, 32'h0, LW, 32'hA5A5_A5A5, 1'b0);
    add(1'b0, 32'h0000_1000, 32'h0, LW, 32'h0, 1'b0);
    add(1'b0, MMIO + 32'h8, 32'h0, LW, exp_stores, 1'b0);
    foreach (ops[i]) begin
      drive(ops[i]); e = exp_q.pop_front();
      n_checks += 2;
      if (ReadData !== e.rd) begin n_fail++; $display("FAIL unmapped[%0d] ReadData got %h expected %h", i, ReadData, e.rd); end
      if (gpio_out !== e.gpio) begin n_fail++; $display("FAIL unmapped[%0d] gpio_out got %h expected %h", i, gpio_out, e.gpio); end
    end
  endtask

  task automatic test_reset_store();
    exp_t e;
    reset = 1'b1; MemWriteM = 1'b1; Mem_WrAddr = MMIO; Mem_WrData = 32'h0000_1234; funct3M = LW;
    @(posedge clk); #1;
    n_checks += 2;
    if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_store gpio_out got %h expected 00000000", gpio_out); end
    if (ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_store ReadData got %h expected 00000000", ReadData); end
    reset = 1'b0; exp_gpio = 32'h0; exp_stores = 32'h0;
    ops.delete();
    add(1'b0, MMIO + 32'h8, 32'h0, LW, 32'h0, 1'b0);
    add(1'b0, MMIO, 32'h0, LW, 32'h0, 1'b0);
    foreach (ops[i]) begin
      drive(ops[i]); e = exp_q.pop_front();
      n_checks += 2;
      if (ReadData !== e.rd) begin n_fail++; $display("FAIL reset_store[%0d] ReadData got %h expected %h", i, ReadData, e.rd); end
      if (gpio_out !== e.gpio) begin n_fail++; $display("FAIL reset_store[%0d] gpio_out got %h expected %h", i, gpio_out, e.gpio); end
    end
  endtask

  initial begin
    test_reset();
    test_mmio();
    test_ram_subword();
    test_back_to_back();
    test_misalign();
    test_unmapped();
    test_reset_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
